// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM coprocessor and the main decoder.
package gcd_lcm_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [6:0] OP_GCD = 7'b0000000;
  localparam logic [6:0] OP_LCM = 7'b0000001;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GCD  = 3'd1,
    DIV  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/gcd_lcm_unit_divider.sv
// Restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]  cnt;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;

  assign rem_sh = {remainder, quotient[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, divisor};
  // rem_sh < 2*divisor, so the borrow bit alone tells whether the subtract fits.
  assign fits   = ~diff[WIDTH];

  // High during the cycle whose closing edge takes the final step; the
  // quotient is complete from the following cycle on.
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      cnt       <= CW'(WIDTH);
      quotient  <= dividend;
      remainder <= '0;
    end else if (cnt != '0) begin
      cnt       <= cnt - CW'(1);
      remainder <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD/LCM coprocessor: binary Stein GCD, then lcm = (a / g) * b.
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             lcm_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output state_t           fsm_state
);

  localparam int KW = $clog2(WIDTH + 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   x, x_n, y, y_n;
  logic [KW-1:0]      k, k_n;
  logic [WIDTH-1:0]   a_q, a_q_n, b_q, b_q_n;
  logic               lcm_q, lcm_q_n;
  logic [WIDTH-1:0]   result_n;
  logic               overflow_n;
  logic [WIDTH-1:0]   g;
  logic               div_start;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem_unused;
  logic               div_done;
  logic [2*WIDTH-1:0] prod;

  assign g    = x << k;
  assign prod = {{WIDTH{1'b0}}, div_quo} * {{WIDTH{1'b0}}, b_q};

  restoring_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (a_q),
    .divisor   (g),
    .quotient  (div_quo),
    .remainder (div_rem_unused),
    .done      (div_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      lcm_q    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      k        <= k_n;
      a_q      <= a_q_n;
      b_q      <= b_q_n;
      lcm_q    <= lcm_q_n;
      result   <= result_n;
      overflow <= overflow_n;
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    k_n        = k;
    a_q_n      = a_q;
    b_q_n      = b_q;
    lcm_q_n    = lcm_q;
    result_n   = result;
    overflow_n = overflow;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_q_n   = a;
          b_q_n   = b;
          lcm_q_n = lcm_sel;
          x_n     = a;
          y_n     = b;
          k_n     = '0;
          if (a == '0 || b == '0) begin
            // With one operand zero, a|b is the other one (or zero).
            result_n   = lcm_sel ? '0 : (a | b);
            overflow_n = 1'b0;
            state_n    = DONE;
          end else begin
            state_n = GCD;
          end
        end
      end
      GCD: begin
        if (x == y) begin
          if (lcm_q) begin
            div_start = 1'b1;
            state_n   = DIV;
          end else begin
            result_n   = g;
            overflow_n = 1'b0;
            state_n    = DONE;
          end
        end else if (!x[0] && !y[0]) begin
          x_n = x >> 1;
          y_n = y >> 1;
          k_n = k + KW'(1);
        end else if (!x[0]) begin
          x_n = x >> 1;
        end else if (!y[0]) begin
          y_n = y >> 1;
        end else if (x > y) begin
          x_n = (x - y) >> 1;
        end else begin
          y_n = (y - x) >> 1;
        end
      end
      DIV: begin
        if (div_done) state_n = MUL;
      end
      MUL: begin
        result_n   = prod[WIDTH-1:0];
        overflow_n = |prod[2*WIDTH-1:WIDTH];
        state_n    = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Directed bench for gcd_lcm_unit: results, overflow, latency, ignored starts, mid-op reset.
module tb_gcd_lcm_unit;
  import gcd_lcm_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        lcm_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  state_t      fsm_state;

  logic [31:0] exp_q[$];
  int          checks;
  int          errors;

  gcd_lcm_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lcm_sel   (lcm_sel),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the first falling edge after the start edge.
  task automatic drive_start(input logic [31:0] op_a, input logic [31:0] op_b, input logic sel);
    @(negedge clk);
    a       = op_a;
    b       = op_b;
    lcm_sel = sel;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 is the cycle index (counted from the start edge) of the current falling edge.
  task automatic wait_done(input string tag, input logic exp_ovf, input int exp_lat, input int n0);
    int          lat;
    logic [31:0] exp_res;
    lat = 0;
    for (int n = n0; n <= 200; n++) begin
      if (n > n0) @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    exp_res = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic sel, input logic [31:0] exp_res, input logic exp_ovf,
                        input int exp_lat);
    exp_q.push_back(exp_res);
    drive_start(op_a, op_b, sel);
    check({tag, "_busy1"}, 64'(busy), 64'(1));
    wait_done(tag, exp_ovf, exp_lat, 1);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int saw_done;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    lcm_sel = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    reset = 1'b0;

    run_op("gcd_48_18", 32'd48, 32'd18, 1'b0, 32'd6, 1'b0, 7);
    run_op("lcm_4_6", 32'd4, 32'd6, 1'b1, 32'd12, 1'b0, 38);
    run_op("gcd_0_25", 32'd0, 32'd25, 1'b0, 32'd25, 1'b0, 1);
    run_op("gcd_0_0", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1);
    run_op("lcm_7_0", 32'd7, 32'd0, 1'b1, 32'd0, 1'b0, 1);
    run_op("lcm_ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'h0000_0002, 1'b1, 97);

    // Reset while dividing: outputs clear and no done pulse follows.
    drive_start(32'd12, 32'd18, 1'b1);
    repeat (6) @(negedge clk);
    check("rst_mid_in_div", 64'(fsm_state), 64'(DIV));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_result", 64'(result), 64'(0));
    check("rst_mid_ovf", 64'(overflow), 64'(0));
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(saw_done), 64'(0));
    run_op("lcm_12_18", 32'd12, 32'd18, 1'b1, 32'd36, 1'b0, 38);

    // A start pulse during GCD is ignored; captured operands are kept.
    exp_q.push_back(32'd25);
    drive_start(32'd100, 32'd75, 1'b0);
    a     = 32'd9;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("gcd_ignored", 1'b0, 5, 2);
    @(negedge clk);
    check("gcd_ignored_idle", 64'(busy), 64'(0));
    run_op("gcd_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 1'b0, 3);

    // Start held high: second operation begins on the first IDLE cycle after DONE.
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd2);
    @(negedge clk);
    a       = 32'd6;
    b       = 32'd4;
    lcm_sel = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    wait_done("held_first", 1'b0, 5, 1);
    @(negedge clk);
    check("held_gap_idle", 64'(busy), 64'(0));
    @(negedge clk);
    wait_done("held_second", 1'b0, 5, 1);
    start = 1'b0;
    @(negedge clk);
    check("held_end_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_lcm_unit.md
# gcd_lcm_unit

Multi-cycle GCD/LCM coprocessor. It is the responder to the main decoder's `Start` / `ALU3SrcA` controls for the custom opcodes `0000000` (gcd) and `0000001` (lcm). It accepts two unsigned register operands, computes the result iteratively, and returns it with a one-cycle `done` pulse on the coprocessor result path (`ResultSrc = 11`). `busy` stalls the core while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  from decoder `Start`; request a new operation.
- `lcm_sel`  in  1  from decoder `ALU3SrcA`; 0 = gcd, 1 = lcm.
- `a`  in  WIDTH  operand rs1, unsigned.
- `b`  in  WIDTH  operand rs2, unsigned.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  WIDTH  gcd, or low WIDTH bits of the lcm.
- `overflow`  out  1  lcm only: the true lcm does not fit in WIDTH bits.

## Operation
- States: IDLE, GCD, DIV, MUL, DONE.
- **IDLE**
  - On `start` = 1: capture `a`, `b` and `lcm_sel`; clear the shift count k.
  - If either operand is 0, go directly to DONE.
  - Otherwise go to GCD.
- **GCD** (binary Stein), one step per cycle on x, y. Priority order:
  - x == y: g = x << k; go to DIV if lcm, else DONE.
  - x and y both even: x >>= 1, y >>= 1, k += 1.
  - x even: x >>= 1.
  - y even: y >>= 1.
  - x > y: x = (x − y) >> 1.
  - otherwise: y = (y − x) >> 1.
- **DIV**: restoring division q = a_captured / g; exactly WIDTH cycles; remainder is always 0 and is discarded.
- **MUL**: 2·WIDTH-bit product p = q · b_captured; `result` = p[WIDTH−1:0]; `overflow` = |p[2·WIDTH−1:WIDTH]; one cycle.
- **DONE**: assert `done` for exactly one cycle, then return to IDLE.
- Zero-operand results:
  - gcd(0,b) = b, gcd(a,0) = a, gcd(0,0) = 0.
  - lcm with any zero operand = 0.
  - `overflow` = 0 in all zero cases.
- gcd always forces `overflow` = 0.
- `result` and `overflow` are written only on entry to DONE. They hold their value through IDLE until the next accepted operation completes.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `overflow` 0, all internal registers 0.
- Accepted start at edge t: `busy` = 1 from t+1 until the cycle after DONE.
- GCD phase: at most 2·WIDTH+1 cycles, because every non-terminating step removes at least one bit from x or y.
- gcd latency: start edge → DONE ≤ 2·WIDTH+2 cycles.
- lcm latency: gcd latency + WIDTH (DIV) + 1 (MUL).
- `start` while `busy` = 1 is ignored. The in-flight operation and captured operands are unaffected.
- `start` in the DONE cycle is ignored. `start` is accepted in IDLE only.
- `start` held high: a new operation is accepted on the first IDLE cycle after DONE.
- Reset mid-operation: next state IDLE, all outputs return to reset values, and no `done` pulse is produced.
- `reset` and `start` in the same cycle: reset wins.

## Structure
- Package `gcd_lcm_pkg`:
  - `state_t` enum (IDLE, GCD, DIV, MUL, DONE).
  - Opcode constants `OP_GCD` = 7'b0000000 and `OP_LCM` = 7'b0000001, shared with the main decoder.
  - Default `WIDTH` constant.
- Sub-module `restoring_divider`, parameterised by WIDTH:
  - Inputs: `start`, dividend, divisor.
  - Outputs: quotient, remainder, `done` after exactly WIDTH cycles.
  - Instantiated once and driven from the DIV state.
- The multiply is a single combinational `*` registered in MUL.

## Test plan
- gcd(48, 18), `lcm_sel` = 0 → `result` = 6, `overflow` = 0. GCD phase takes 6 cycles, so `done` is asserted 7 cycles after the start edge.
- lcm(4, 6) → `result` = 12, `overflow` = 0. Latency = 4 (GCD) + 32 (DIV) + 1 (MUL) + 1 = 38 cycles.
- Zero operands:
  - gcd(0, 25) → 25.
  - gcd(0, 0) → 0.
  - lcm(7, 0) → 0.
  - Each produces `done` 1 cycle after the start edge.
- lcm(0xFFFFFFFF, 0xFFFFFFFE) → g = 1, `result` = 0x00000002, `overflow` = 1.
- Start gcd(100, 75), then pulse `start` with a = 9, b = 3 mid-operation → the second start is ignored and `result` = 25. A new start after DONE gives 3.
- Assert `reset` during the DIV state of lcm(12, 18) → next cycle `busy` = 0, `result` = 0, no `done` pulse. A subsequent lcm(12, 18) → 36.
